// File: rtl/loop_seq_pkg.sv
// Shared types and defaults for the i/j/k loop index sequencer.
// Levels are numbered innermost first: 0 = k, 1 = j, 2 = i.
package loop_seq_pkg;

    localparam int W_DEF    = 8;
    localparam int N_LEVELS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/loop_level.sv
// One loop level: latched trip count plus a shadow copy of the external
// counter register, driven by the same clear/increment strobes it emits.
module loop_level
    import loop_seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] bound_val_i,
    input  logic         clear_i,
    input  logic         advance_i,
    output logic [W-1:0] idx_o,
    output logic         last_o,
    output logic         inc_o,
    output logic         clr_o
);

    logic [W-1:0] bound_q;
    logic [W-1:0] bound_d;
    logic [W-1:0] idx_q;
    logic [W-1:0] idx_d;

    // A zero bound never reaches RUN, so the wrap of bound_q - 1 is harmless.
    assign last_o = (idx_q == (bound_q - W'(1)));
    assign inc_o  = advance_i && !last_o;
    assign clr_o  = clear_i || (advance_i && last_o);
    assign idx_o  = idx_q;

    always_comb begin
        bound_d = bound_q;
        if (load_i) begin
            bound_d = bound_val_i;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (clr_o) begin
            idx_d = '0;
        end else if (inc_o) begin
            idx_d = idx_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bound_q <= '0;
            idx_q   <= '0;
        end else begin
            bound_q <= bound_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/loop_index_sequencer.sv
// Sequences three external clear/increment counter registers as a nested
// i/j/k loop, presenting one iteration per non-stalled RUN cycle.
module loop_index_sequencer
    import loop_seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bound_i,
    input  logic [W-1:0] bound_j,
    input  logic [W-1:0] bound_k,
    input  logic         stall,
    output logic         clr_i,
    output logic         clr_j,
    output logic         clr_k,
    output logic         inc_i,
    output logic         inc_j,
    output logic         inc_k,
    output logic [W-1:0] idx_i,
    output logic [W-1:0] idx_j,
    output logic [W-1:0] idx_k,
    output logic         iter_valid,
    output logic         busy,
    output logic         done
);

    state_e state_q;
    state_e state_d;

    logic                load;
    logic                clear_all;
    logic                bound_zero;
    logic [N_LEVELS-1:0] adv;
    logic [N_LEVELS-1:0] last;
    logic [N_LEVELS-1:0] inc;
    logic [N_LEVELS-1:0] clr;
    logic [W-1:0]        bound_arr [N_LEVELS];
    logic [W-1:0]        idx_arr   [N_LEVELS];

    assign bound_arr[0] = bound_k;
    assign bound_arr[1] = bound_j;
    assign bound_arr[2] = bound_i;
    assign bound_zero   = (bound_i == '0) || (bound_j == '0) || (bound_k == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = bound_zero ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (adv[N_LEVELS-1] && last[N_LEVELS-1]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Everything is forced quiet while reset is held, whatever state_q holds.
    always_comb begin
        load       = 1'b0;
        clear_all  = 1'b0;
        iter_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        if (!reset) begin
            load       = (state_q == ST_IDLE) && start;
            clear_all  = (state_q == ST_CLEAR);
            iter_valid = (state_q == ST_RUN) && !stall;
            busy       = (state_q != ST_IDLE);
            done       = (state_q == ST_DONE);
        end
    end

    // An outer level advances only when every inner level wraps this cycle.
    assign adv[0] = iter_valid;

    generate
        for (genvar gi = 1; gi < N_LEVELS; gi++) begin : g_chain
            assign adv[gi] = adv[gi-1] && last[gi-1];
        end

        for (genvar gi = 0; gi < N_LEVELS; gi++) begin : g_level
            loop_level #(
                .W(W)
            ) u_level (
                .clk        (clk),
                .reset      (reset),
                .load_i     (load),
                .bound_val_i(bound_arr[gi]),
                .clear_i    (clear_all),
                .advance_i  (adv[gi]),
                .idx_o      (idx_arr[gi]),
                .last_o     (last[gi]),
                .inc_o      (inc[gi]),
                .clr_o      (clr[gi])
            );
        end
    endgenerate

    assign clr_k = clr[0];
    assign clr_j = clr[1];
    assign clr_i = clr[2];
    assign inc_k = inc[0];
    assign inc_j = inc[1];
    assign inc_i = inc[2];
    assign idx_k = idx_arr[0];
    assign idx_j = idx_arr[1];
    assign idx_i = idx_arr[2];

endmodule

// File: tb/tb_loop_index_sequencer.sv
// Directed bench for loop_index_sequencer: expected iteration order and
// strobes are rebuilt from nested loops; an external-register model runs alongside.
module tb_loop_index_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] bound_i;
    logic [7:0] bound_j;
    logic [7:0] bound_k;
    logic       stall;
    logic       clr_i, clr_j, clr_k;
    logic       inc_i, inc_j, inc_k;
    logic [7:0] idx_i, idx_j, idx_k;
    logic       iter_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    int iter_cnt = 0;
    bit mon_en   = 1'b0;

    logic [7:0] ext_i, ext_j, ext_k;

    loop_index_sequencer #(.W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bound_i   (bound_i),
        .bound_j   (bound_j),
        .bound_k   (bound_k),
        .stall     (stall),
        .clr_i     (clr_i),
        .clr_j     (clr_j),
        .clr_k     (clr_k),
        .inc_i     (inc_i),
        .inc_j     (inc_j),
        .inc_k     (inc_k),
        .idx_i     (idx_i),
        .idx_j     (idx_j),
        .idx_k     (idx_k),
        .iter_valid(iter_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // External counter registers: clear has priority over increment.
    always @(posedge clk) begin
        if (clr_i) ext_i <= 8'd0; else if (inc_i) ext_i <= ext_i + 8'd1;
        if (clr_j) ext_j <= 8'd0; else if (inc_j) ext_j <= ext_j + 8'd1;
        if (clr_k) ext_k <= 8'd0; else if (inc_k) ext_k <= ext_k + 8'd1;
    end

    always @(negedge clk) begin
        #2;
        if (iter_valid === 1'b1) iter_cnt++;
        check("excl", {29'd0, clr_i & inc_i, clr_j & inc_j, clr_k & inc_k}, 32'd0);
        if (mon_en) begin
            check("shadow", {8'd0, idx_i, idx_j, idx_k}, {8'd0, ext_i, ext_j, ext_k});
        end
    end

    function automatic logic [5:0] strobes();
        return {clr_i, clr_j, clr_k, inc_i, inc_j, inc_k};
    endfunction

    // stall_at / pulse_at / abort_at are flat iteration numbers, -1 = unused.
    task automatic run_nest(input int bi, input int bj, input int bk,
                            input int stall_at, input int stall_len,
                            input int pulse_at, input int abort_at);
        int  n;
        int  c0;
        bit  kl, jl, il;
        logic [5:0] exp_s;
        $display("run bounds=(%0d,%0d,%0d) stall_at=%0d pulse_at=%0d abort_at=%0d",
                 bi, bj, bk, stall_at, pulse_at, abort_at);
        @(negedge clk);
        c0      = iter_cnt;
        start   = 1'b1;
        bound_i = 8'(bi);
        bound_j = 8'(bj);
        bound_k = 8'(bk);
        @(negedge clk);
        start   = 1'b0;
        bound_i = 8'd7;
        bound_j = 8'd7;
        bound_k = 8'd7;
        #1;
        if (bi == 0 || bj == 0 || bk == 0) begin
            check("zero_done", {31'd0, done}, 32'd1);
            check("zero_busy", {31'd0, busy}, 32'd1);
            check("zero_valid", {31'd0, iter_valid}, 32'd0);
            check("zero_strb", {26'd0, strobes()}, 32'd0);
            @(negedge clk);
            #1;
            check("zero_idle", {30'd0, busy, done}, 32'd0);
            check("zero_iters", iter_cnt - c0, 32'd0);
            return;
        end
        check("clear_strb", {26'd0, strobes()}, 32'b111000);
        check("clear_valid", {31'd0, iter_valid}, 32'd0);
        check("clear_busy", {31'd0, busy}, 32'd1);
        n = 0;
        for (int i = 0; i < bi; i++) begin
            for (int j = 0; j < bj; j++) begin
                for (int k = 0; k < bk; k++) begin
                    if (n == abort_at) begin
                        @(negedge clk);
                        mon_en = 1'b0;
                        start  = 1'b0;
                        reset  = 1'b1;
                        #1;
                        check("rst_strb", {26'd0, strobes()}, 32'd0);
                        @(negedge clk);
                        reset = 1'b0;
                        #1;
                        check("rst_busy", {31'd0, busy}, 32'd0);
                        check("rst_done", {31'd0, done}, 32'd0);
                        check("rst_idx", {8'd0, idx_i, idx_j, idx_k}, 32'd0);
                        check("rst_valid", {31'd0, iter_valid}, 32'd0);
                        return;
                    end
                    if (n == stall_at) begin
                        for (int s = 0; s < stall_len; s++) begin
                            @(negedge clk);
                            start = 1'b0;
                            stall = 1'b1;
                            #1;
                            check("stall_valid", {31'd0, iter_valid}, 32'd0);
                            check("stall_strb", {26'd0, strobes()}, 32'd0);
                            check("stall_idx", {8'd0, idx_i, idx_j, idx_k},
                                  {8'd0, 8'(i), 8'(j), 8'(k)});
                        end
                    end
                    @(negedge clk);
                    stall  = 1'b0;
                    mon_en = 1'b1;
                    start  = (n == pulse_at);
                    if (n == pulse_at) begin
                        bound_i = 8'd5;
                        bound_j = 8'd5;
                        bound_k = 8'd5;
                    end
                    #1;
                    kl    = (k == bk - 1);
                    jl    = (j == bj - 1);
                    il    = (i == bi - 1);
                    exp_s = {kl && jl && il, kl && jl, kl, kl && jl && !il, kl && !jl, !kl};
                    $display("  iter (%0d,%0d,%0d) idx=(%0d,%0d,%0d) strobes=%b",
                             i, j, k, idx_i, idx_j, idx_k, strobes());
                    check("iter_valid", {31'd0, iter_valid}, 32'd1);
                    check("iter_idx", {8'd0, idx_i, idx_j, idx_k},
                          {8'd0, 8'(i), 8'(j), 8'(k)});
                    check("iter_strb", {26'd0, strobes()}, {26'd0, exp_s});
                    n++;
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_valid", {31'd0, iter_valid}, 32'd0);
        check("done_strb", {26'd0, strobes()}, 32'd0);
        check("done_idx", {8'd0, idx_i, idx_j, idx_k}, 32'd0);
        @(negedge clk);
        #1;
        check("idle_after", {30'd0, busy, done}, 32'd0);
        check("iters", iter_cnt - c0, 32'(bi * bj * bk));
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stall   = 1'b0;
        bound_i = 8'd0;
        bound_j = 8'd0;
        bound_k = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_valid", {31'd0, iter_valid}, 32'd0);
        check("reset_strb", {26'd0, strobes()}, 32'd0);
        check("reset_idx", {8'd0, idx_i, idx_j, idx_k}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_nest(2, 2, 3, -1, 0, -1, -1);
        run_nest(1, 1, 1, -1, 0, -1, -1);
        run_nest(2, 0, 3, -1, 0, -1, -1);
        run_nest(1, 2, 2, 1, 3, -1, -1);
        run_nest(2, 2, 3, -1, 0, -1, 8);
        run_nest(2, 2, 3, -1, 0, -1, -1);
        run_nest(2, 2, 3, -1, 0, 4, -1);
        run_nest(3, 1, 2, 2, 1, -1, -1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/loop_index_sequencer.md
Name: loop_index_sequencer

Overview:
Control FSM that sequences three external 8-bit counter registers (write/clear/increment type, priority write_en > reset > inc) as a nested i/j/k loop.
- Per register it drives clear and increment strobes; it never drives write_en.
- It keeps shadow copies of the three indices, so the datapath sees one iteration per non-stalled cycle.
- Sits between the processor control unit (start/done handshake) and the index/address registers of the processor datapath.

Parameters:
W, 8, index and bound width.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  begin a loop nest; sampled only in IDLE
bound_i  in  W  outer loop trip count, latched on accepted start
bound_j  in  W  middle loop trip count, latched on accepted start
bound_k  in  W  inner loop trip count, latched on accepted start
stall  in  1  datapath backpressure; freezes iteration
clr_i  out  1  clear strobe to the external i register
clr_j  out  1  clear strobe to the external j register
clr_k  out  1  clear strobe to the external k register
inc_i  out  1  increment strobe to the external i register
inc_j  out  1  increment strobe to the external j register
inc_k  out  1  increment strobe to the external k register
idx_i  out  W  shadow index, equals the external register value
idx_j  out  W  shadow index, equals the external register value
idx_k  out  W  shadow index, equals the external register value
iter_valid  out  1  current idx_* form a valid iteration this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final iteration

Behaviour:
- Reset (any state, including mid-loop):
  - Next state IDLE.
  - idx_*, latched bounds = 0.
  - done, busy, iter_valid, inc_* = 0.
  - clr_* = 0 during reset.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start=1 latches bounds.
  - If any bound = 0: go to DONE. Zero iterations, no strobes.
  - Otherwise: go to CLEAR.
- CLEAR (1 cycle):
  - clr_i = clr_j = clr_k = 1.
  - Shadow indices reset to 0 at the same edge.
  - Next state RUN.
- RUN, stall=1:
  - iter_valid=0, all strobes 0.
  - Indices hold; stay in RUN.
- RUN, stall=0:
  - iter_valid=1; idx_* is the current iteration.
  - Advance, with strobes combinational from state, stall and shadow indices:
    - k_last = (idx_k == bound_k-1). If not k_last: inc_k.
    - If k_last: clr_k. Then if idx_j != bound_j-1: inc_j.
    - If k_last and j_last: clr_j. Then if idx_i != bound_i-1: inc_i.
    - If i_last, j_last and k_last all hold: clr_i, clr_j, clr_k, and next state DONE.
- Per-register strobe rules:
  - clr_x and inc_x are never both 1 in the same cycle.
  - Shadow counters apply exactly the same strobes, so idx_* tracks the external registers with zero lag.
- DONE (1 cycle):
  - done=1; next state IDLE.
  - All indices are 0 on exit.
- start while busy: ignored, with no effect on bounds.
- Bounds are compared against latched copies only. Changes on bound_* inputs while busy have no effect.
- Total iter_valid cycles = bound_i*bound_j*bound_k, maximum 255^3.
- bound = 1: that level strobes only clr, never inc.
- No index overflow is possible, since idx < bound ≤ 255.

Decomposition:
- Shared package loop_seq_pkg:
  - state enum (IDLE, CLEAR, RUN, DONE)
  - W default
- One natural sub-module loop_level: a shadow counter with latched bound.
  - Inputs: clear, advance.
  - Outputs: idx, last, inc_o, clr_o.
  - Instantiated three times, chained through advance = lower level's advance && last.

Test Plan:
- Bounds (2,2,3), start, no stall:
  - CLEAR for 1 cycle, then 12 iter_valid cycles.
  - (i,j,k) sequence 000,001,002,010,...,112.
  - done pulses 1 cycle after 112; all idx = 0 afterwards.
- Bounds (1,1,1):
  - CLEAR, one iteration (0,0,0) with all clr_* = 1 and inc_* = 0.
  - Then DONE, then IDLE.
- Bound_j = 0:
  - IDLE -> DONE directly.
  - done=1, iter_valid never asserted, no clr/inc strobes.
- Bounds (1,2,2) with stall high for 3 cycles at iteration (0,0,1):
  - idx holds at 001, all strobes 0 while stalled.
  - Resumes with clr_k + inc_j.
  - 4 iterations in total.
- Reset asserted mid-RUN at (1,0,2) of bounds (2,2,3):
  - Next cycle: IDLE, busy=0, idx=0, no done.
  - A new start completes a full 12-iteration run.
- start pulsed during RUN with different bounds:
  - Ignored; the original trip count completes unchanged.
- Checker on every scenario: clr_x & inc_x never both 1, and idx_* equals a reference model of the external registers each cycle.
